// File: rtl/alu_regfile_pipe_pkg.sv
// Shared definitions for the ALU + register file pipeline.
// Holds default widths and the ALU opcode type.
package ALU_REGFILE_defs;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int RF_DEPTH_DEF   = 32;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_SUBA  = 3'd2,
    OP_ORAB  = 3'd3,
    OP_ANDAB = 3'd4,
    OP_NOTAB = 3'd5,
    OP_EXOR  = 3'd6,
    OP_EXNOR = 3'd7
  } aluop_t;

endpackage

// File: rtl/alu_regfile_pipe_alu_core.sv
// Combinational ALU datapath.
// Result is DATA_WIDTH+1 bits; MSB is carry/borrow, 0 for logic ops.
module alu_core
  import ALU_REGFILE_defs::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  aluop_t                op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH:0]   y
);

  always_comb begin
    y = '0;
    unique case (op)
      OP_ADD:   y = {1'b0, a} + {1'b0, b};
      OP_SUB:   y = {1'b0, a} - {1'b0, b};
      OP_SUBA:  y = {1'b0, b} - {1'b0, a};
      OP_ORAB:  y = {1'b0, a | b};
      OP_ANDAB: y = {1'b0, a & b};
      OP_NOTAB: y = {1'b0, ~(a & b)};
      OP_EXOR:  y = {1'b0, a ^ b};
      OP_EXNOR: y = {1'b0, ~(a ^ b)};
    endcase
  end

endmodule

// File: rtl/alu_regfile_pipe.sv
// Two-stage ALU pipeline around a register file.
// Define ALU_FWD_EN to forward stage-1 results instead of stalling.
module alu_regfile_pipe
  import ALU_REGFILE_defs::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int RF_DEPTH   = RF_DEPTH_DEF,
  parameter int ADDR_WIDTH = $clog2(RF_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  aluop_t                in_op,
  input  logic [ADDR_WIDTH-1:0] in_ra,
  input  logic [ADDR_WIDTH-1:0] in_rb,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  ld_en,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH:0]   ld_data,
  output logic                  res_valid,
  output logic [DATA_WIDTH:0]   res_data,
  output logic [ADDR_WIDTH-1:0] res_rd,
  output logic                  res_zero
);

  typedef logic [DATA_WIDTH:0]   word_t;
  typedef logic [DATA_WIDTH-1:0] opnd_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  function automatic logic in_rng(input addr_t ad);
    return {1'b0, ad} < (ADDR_WIDTH+1)'(RF_DEPTH);
  endfunction

  word_t  rf_q [RF_DEPTH];
  word_t  rf_d [RF_DEPTH];
  logic   s1_valid_q, s1_valid_d;
  aluop_t s1_op_q, s1_op_d;
  opnd_t  s1_a_q, s1_a_d;
  opnd_t  s1_b_q, s1_b_d;
  addr_t  s1_rd_q, s1_rd_d;
  logic   res_valid_q, res_valid_d;
  word_t  res_data_q, res_data_d;
  addr_t  res_rd_q, res_rd_d;
  logic   res_zero_q, res_zero_d;

  word_t alu_y;
  opnd_t rd_a, rd_b, op_a, op_b;
  logic  hit_a, hit_b, stall, accept;

  alu_core #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .op(s1_op_q),
    .a (s1_a_q),
    .b (s1_b_q),
    .y (alu_y)
  );

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (in_rng(in_ra)) rd_a = rf_q[in_ra][DATA_WIDTH-1:0];
    if (in_rng(in_rb)) rd_b = rf_q[in_rb][DATA_WIDTH-1:0];
    hit_a = s1_valid_q && in_rng(in_ra) && (s1_rd_q == in_ra);
    hit_b = s1_valid_q && in_rng(in_rb) && (s1_rd_q == in_rb);
`ifdef ALU_FWD_EN
    op_a  = hit_a ? alu_y[DATA_WIDTH-1:0] : rd_a;
    op_b  = hit_b ? alu_y[DATA_WIDTH-1:0] : rd_b;
    stall = 1'b0;
`else
    op_a  = rd_a;
    op_b  = rd_b;
    stall = hit_a || hit_b;
`endif
    in_ready = !reset && !ld_en && !stall;
    accept   = in_valid && in_ready;
  end

  always_comb begin
    rf_d = rf_q;
    // Load is applied last so it overrides a same-address writeback.
    if (s1_valid_q && in_rng(s1_rd_q)) rf_d[s1_rd_q] = alu_y;
    if (ld_en && in_rng(ld_addr)) rf_d[ld_addr] = ld_data;
    s1_valid_d  = accept;
    s1_op_d     = accept ? in_op : s1_op_q;
    s1_a_d      = accept ? op_a  : s1_a_q;
    s1_b_d      = accept ? op_b  : s1_b_q;
    s1_rd_d     = accept ? in_rd : s1_rd_q;
    res_valid_d = s1_valid_q;
    res_data_d  = s1_valid_q ? alu_y : res_data_q;
    res_rd_d    = s1_valid_q ? s1_rd_q : res_rd_q;
    res_zero_d  = s1_valid_q ? (alu_y == '0) : res_zero_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OP_ADD;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_rd_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_rd_q    <= '0;
      res_zero_q  <= 1'b0;
    end else begin
      rf_q        <= rf_d;
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_rd_q     <= s1_rd_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_rd_q    <= res_rd_d;
      res_zero_q  <= res_zero_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_rd    = res_rd_q;
  assign res_zero  = res_zero_q;

endmodule
